// File: rtl/srl_shift_fifo_if.sv
// Producer/consumer port bundle for srl_shift_fifo.
// With SRL_SHIFT_FIFO_ERR_EN defined the bundle also carries the sticky err flag.
interface srl_shift_fifo_if #(
    parameter int WIDTH = 8
);
    // Handshake: a push happens on a rising edge with wr_en high while (!full || rd_en).
    // A pop happens on a rising edge with rd_en high while !empty. dout is valid whenever !empty.
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [4:0]       count;
`ifdef SRL_SHIFT_FIFO_ERR_EN
    logic             err;

    modport master (
        output wr_en, din, rd_en,
        input  dout, empty, full, count, err
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, empty, full, count, err
    );
`else
    modport master (
        output wr_en, din, rd_en,
        input  dout, empty, full, count
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, empty, full, count
    );
`endif
endinterface

// File: rtl/srl_shift_fifo.sv
// 16-deep first-word-fall-through FIFO on SRL16-style shift storage with a count-driven read address.
// Optional sticky overflow/underflow flag enabled by defining SRL_SHIFT_FIFO_ERR_EN.
module srl_shift_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    srl_shift_fifo_if.slave  fifo_if
);
    localparam int AW = 4;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             empty;
    logic             full;
    logic             wr_accept;
    logic             rd_accept;
    logic [AW-1:0]    rd_addr;

    assign empty = (count_q == '0);
    assign full  = (count_q == 5'(DEPTH));

    // A write into a full FIFO is legal only when the oldest word leaves on the same edge.
    assign wr_accept = fifo_if.wr_en && (!full || fifo_if.rd_en);
    assign rd_accept = fifo_if.rd_en && !empty;

    // At count 16 the low nibble is 0, so the 4-bit subtract wraps to address 15.
    assign rd_addr = count_q[AW-1:0] - 4'd1;

    // No reset and a single enable so each bit column maps onto one SRL16 primitive.
    // Shifts during reset are harmless because count is held at zero.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                data_q[i] <= data_q[i-1];
            end
            data_q[0] <= fifo_if.din;
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 5'd1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        fifo_if.dout = '0;
        if (!empty) begin
            fifo_if.dout = data_q[rd_addr];
        end
    end

    assign fifo_if.empty = empty;
    assign fifo_if.full  = full;
    assign fifo_if.count = count_q;

`ifdef SRL_SHIFT_FIFO_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if ((fifo_if.wr_en && full && !fifo_if.rd_en) || (fifo_if.rd_en && empty)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fifo_if.err = err_q;
`endif

endmodule
